// File: rtl/i2s_tx.sv
// Philips I2S transmitter: one stereo pair per frame, 256 mclk per frame,
// 32-bit slots, per-frame sample request and saturating underrun counter.
module i2s_tx #(
   parameter int SAMPLE_BITS   = 16,
   parameter int UNDERRUN_BITS = 16
) (
   input  logic                     mclk,
   input  logic                     rst,
   input  logic [SAMPLE_BITS-1:0]   sample_l,
   input  logic [SAMPLE_BITS-1:0]   sample_r,
   input  logic                     sample_valid,
   output logic                     sample_req,
   output logic                     bclk,
   output logic                     lrclk,
   output logic                     sdata,
   output logic [UNDERRUN_BITS-1:0] underrun_cnt
);

   logic [7:0]               cnt_q, cnt_d;
   logic [SAMPLE_BITS-1:0]   hold_l_q, hold_l_d, hold_r_q, hold_r_d;
   logic [SAMPLE_BITS-1:0]   word_l_q, word_l_d, word_r_q, word_r_d;
   logic                     fresh_q, fresh_d, armed_q, armed_d;
   logic [UNDERRUN_BITS-1:0] urun_q, urun_d;
   logic                     bclk_q, bclk_d, lrclk_q, lrclk_d;
   logic                     sdata_q, sdata_d, req_q, req_d;

   logic                     latch;
   logic [4:0]               k_nxt;
   logic [SAMPLE_BITS-1:0]   word_sel;

   always_comb begin
      cnt_d    = cnt_q + 8'd1;
      latch    = (cnt_q == 8'hFF);

      hold_l_d = sample_valid ? sample_l : hold_l_q;
      hold_r_d = sample_valid ? sample_r : hold_r_q;
      // The latch takes the holding values from before this edge, so a valid
      // landing on the latch edge is kept for the following frame.
      word_l_d = latch ? hold_l_q : word_l_q;
      word_r_d = latch ? hold_r_q : word_r_q;
      fresh_d  = latch ? sample_valid : (fresh_q | sample_valid);
      armed_d  = armed_q | sample_valid;

      urun_d   = urun_q;
      if (latch && !fresh_q && armed_q && !(&urun_q))
         urun_d = urun_q + UNDERRUN_BITS'(1);

      // Outputs are computed from the next count so the registers match cnt.
      k_nxt    = cnt_d[6:2];
      word_sel = cnt_d[7] ? word_r_q : word_l_q;
      sdata_d  = 1'b0;
      for (int i = 0; i < SAMPLE_BITS; i++)
         if (k_nxt == 5'(SAMPLE_BITS - i)) sdata_d = word_sel[i];

      bclk_d   = cnt_d[1];
      lrclk_d  = cnt_d[7];
      req_d    = (cnt_d == 8'd0);
   end

   always_ff @(posedge mclk or negedge rst) begin
      if (!rst) begin
         cnt_q    <= '0;
         hold_l_q <= '0;
         hold_r_q <= '0;
         word_l_q <= '0;
         word_r_q <= '0;
         fresh_q  <= 1'b0;
         armed_q  <= 1'b0;
         urun_q   <= '0;
         bclk_q   <= 1'b0;
         lrclk_q  <= 1'b0;
         sdata_q  <= 1'b0;
         req_q    <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         hold_l_q <= hold_l_d;
         hold_r_q <= hold_r_d;
         word_l_q <= word_l_d;
         word_r_q <= word_r_d;
         fresh_q  <= fresh_d;
         armed_q  <= armed_d;
         urun_q   <= urun_d;
         bclk_q   <= bclk_d;
         lrclk_q  <= lrclk_d;
         sdata_q  <= sdata_d;
         req_q    <= req_d;
      end
   end

   assign sample_req   = req_q;
   assign bclk         = bclk_q;
   assign lrclk        = lrclk_q;
   assign sdata        = sdata_q;
   assign underrun_cnt = urun_q;

endmodule

// File: doc/i2s_tx.md
# i2s_tx

Audio sink at the far end of the sample path: accepts one stereo pair of 16-bit signed samples per frame from the source/mixer chain (the `valid`-qualified output of the synth sources) and serialises it to the codec as standard Philips I2S. All timing derives from `mclk` (256 × Fs): BCLK = 64 × Fs with 32-bit slots, LRCLK = Fs. The block also issues a per-frame sample request and counts underruns.

## Interface
- `SAMPLE_BITS`, 16: sample width; must be ≤ 31.
- `UNDERRUN_BITS`, 16: width of the saturating underrun counter.
- `mclk` in 1: master clock, 256 × Fs.
- `rst` in 1: asynchronous reset, active-low. Output registers clear immediately on assertion; the block runs again from the first `mclk` edge after release.
- `sample_l` in SAMPLE_BITS: left sample, signed.
- `sample_r` in SAMPLE_BITS: right sample, signed. Mono sources drive the same value on both.
- `sample_valid` in 1: qualifies `sample_l`/`sample_r`. Any pulse length is allowed; the pair is captured on every cycle this is high.
- `sample_req` out 1: one-cycle pulse once per frame, when a new frame starts.
- `bclk` out 1: bit clock, `mclk`/4.
- `lrclk` out 1: word select. 0 = left, 1 = right.
- `sdata` out 1: serial data, MSB first.
- `underrun_cnt` out UNDERRUN_BITS: saturating count of frames with no fresh sample.

## Operation
- **Frame counter** `cnt[7:0]`:
  - Free-running and wraps 255→0.
  - Field split: `ch = cnt[7]`, `k = cnt[6:2]` (slot bit 0..31), `ph = cnt[1:0]`.
- **Holding registers** `hold_l`/`hold_r` and `fresh` flag:
  - On `sample_valid`, load both holding registers from the inputs and set `fresh` = 1.
- **Frame latch**, on the edge where `cnt` goes 255→0:
  - Load `word_l` ← `hold_l` and `word_r` ← `hold_r`, using the holding values from *before* this edge.
  - `fresh` ← `sample_valid`. A valid arriving on the latch edge is kept for the next frame.
  - If the old `fresh` was 0 and `armed` = 1, increment `underrun_cnt`; it saturates at all-ones.
  - On underrun the previous words repeat, since the holding registers are unchanged.
- **`armed`**: set by the first `sample_valid` after reset. Underruns are not counted before it is set.
- **`sample_req`**: high for exactly the one cycle where `cnt` = 0.
- **Serial format** (Philips I2S, one-BCLK delay after the LRCLK edge), per channel slot:
  - `k` = 0: `sdata` = 0. This is the delayed padding bit of the previous slot.
  - `k` = 1..SAMPLE_BITS: `sdata` = `word[SAMPLE_BITS−k]`. MSB at `k` = 1, LSB at `k` = SAMPLE_BITS.
  - `k` > SAMPLE_BITS: `sdata` = 0.
  - `word` = `word_l` when `ch` = 0 and `word_r` when `ch` = 1.

## Timing
- **Reset values**: `cnt` = 0, `bclk` = 0, `lrclk` = 0, `sdata` = 0, `sample_req` = 0, `underrun_cnt` = 0, `hold_*` = 0, `word_*` = 0, `fresh` = 0, `armed` = 0.
- **Output registers**: `bclk`, `lrclk` and `sdata` are all registered. Each is glitch-free and reflects the current `cnt`:
  - `bclk` = 0 while `ph` ∈ {0,1} and 1 while `ph` ∈ {2,3}.
  - `lrclk` = `ch`.
  - `sdata` holds the bit for slot (`ch`,`k`) for all four `mclk` cycles of that slot.
  - `sdata` therefore changes only at BCLK falling edges and is stable across each rising edge.
- **Derived periods**:
  - BCLK period: 4 `mclk`.
  - LRCLK period: 256 `mclk`, toggling at `cnt` 0 and 128.
  - `sample_req` period: 256 `mclk`.
- **Latency**:
  - A pair accepted at any `cnt` ≤ 254 appears starting in the next frame. Its left MSB is driven during `cnt` 4..7 of that frame.
  - A pair accepted at `cnt` = 255 appears one frame later.
- **First frame after reset** outputs all zeros. No underrun is counted, because `armed` = 0.
- **Reset mid-frame**: all outputs drop to reset values asynchronously. No partial word resumes; the frame restarts cleanly at `cnt` = 0.
- **Multiple valids within one frame**: the last one wins.

## Test plan
- **Reset and clocks**: assert `rst` low for 10 cycles, then release.
  - During reset: all outputs are 0.
  - After release: `bclk` toggles every 2 `mclk`, and `lrclk` rises at `cnt` 128 and falls at `cnt` 0.
  - `sample_req` pulses once every 256 cycles.
- **Data format**: pulse `sample_valid` at `cnt` 50 with L = 0x8001, R = 0x7FFE.
  - Next frame, left slot `k` = 0..31 reads 0, 1000000000000001, then fifteen 0s.
  - Right slot reads 0, 0111111111111110, then fifteen 0s.
  - `underrun_cnt` = 0.
- **Underrun**: feed samples for 3 frames, then skip one frame.
  - The skipped frame repeats the prior words exactly.
  - `underrun_cnt` = 1.
  - Resuming the feed adds no further counts.
- **Latch-edge collision**: frame N's latch edge sees `fresh` = 1 from a valid with 0x1111. On the latch edge itself (`cnt` = 255), pulse `sample_valid` with 0x2222.
  - Frame N+1 outputs 0x1111.
  - Frame N+2 outputs 0x2222.
  - `underrun_cnt` is unchanged.
- **Underrun saturation**: set `UNDERRUN_BITS` = 4 and arm with one sample, then starve for 20 frames.
  - `underrun_cnt` reaches 15 and holds at 15.
- **Mid-frame reset**: assert `rst` low at `cnt` = 100 while `sdata` = 1.
  - `sdata`, `bclk` and `lrclk` go to 0 within the same cycle.
  - After release: the first frame is all zeros, `underrun_cnt` = 0, and no underrun is counted until a new valid arms the block.
